// File: rtl/rv32c_sp_mem_ctrl.sv
// Multi-cycle controller for RV32C c.lwsp / c.swsp that owns the shared data-RAM
// port and arbitrates it with an instruction-fetch requester.
module rv32c_sp_mem_ctrl #(
  parameter int RAM_LAT = 1
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iVALID,
  input  logic [15:0] iIR,
  input  logic [31:0] iSP,
  input  logic [31:0] iRS2_DATA,
  output logic [4:0]  oRS2,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERR,
  output logic        oWB_EN,
  output logic [4:0]  oWB_RD,
  output logic [31:0] oWB_DATA,
  input  logic        iIF_REQ,
  input  logic [7:0]  iIF_ADDR,
  output logic        oIF_VLD,
  output logic [31:0] oIF_DATA,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [7:0]  oRAM_ADDR,
  output logic [31:0] oRAM_WDATA,
  input  logic [31:0] iRAM_DATA
);

  typedef enum logic [3:0] {
    S_IDLE, S_D_RD, S_F_RD, S_WAIT, S_D_WB, S_F_DONE, S_D_WR, S_D_FIN, S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fetch_q, fetch_d;

  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        wb_en_q, wb_en_d, if_vld_q, if_vld_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d, if_data_q, if_data_d;
  logic        ram_ce_q, ram_ce_d, ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;

  logic        is_lw, is_sw, fault;
  logic [7:0]  offset;
  logic [31:0] sum;
  logic        unused_sum_hi;

  assign is_lw  = (iIR[1:0] == 2'b10) && (iIR[15:13] == 3'b010);
  assign is_sw  = (iIR[1:0] == 2'b10) && (iIR[15:13] == 3'b110);
  assign offset = is_lw ? {iIR[3:2], iIR[12], iIR[6:4], 2'b00}
                        : {iIR[8:7], iIR[12:9], 2'b00};
  assign sum    = iSP + {24'd0, offset};
  assign fault  = (sum[1:0] != 2'b00) || (is_lw && (iIR[11:7] == 5'd0));
  // Only sum[9:2] forms the word address; the upper bits wrap away.
  assign unused_sum_hi = ^sum[31:10];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    fetch_d     = fetch_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    if_data_d   = if_data_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (iVALID && (is_lw || is_sw)) begin
          if (fault) begin
            state_d = S_FAULT;
          end else begin
            addr_d  = sum[9:2];
            rd_d    = iIR[11:7];
            wdata_d = iRS2_DATA;
            fetch_d = 1'b0;
            state_d = is_lw ? S_D_RD : S_D_WR;
          end
        end else if (iIF_REQ) begin
          addr_d  = iIF_ADDR;
          fetch_d = 1'b1;
          state_d = S_F_RD;
        end
      end
      S_D_RD, S_F_RD: begin
        cnt_d   = 3'(RAM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (fetch_q) begin
            if_data_d = iRAM_DATA;
            state_d   = S_F_DONE;
          end else begin
            wb_data_d = iRAM_DATA;
            state_d   = S_D_WB;
          end
        end
      end
      S_D_WR:  state_d = S_D_FIN;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    busy_d   = (state_d != S_IDLE);
    ram_rd_d = (state_d == S_D_RD) || (state_d == S_F_RD);
    ram_wr_d = (state_d == S_D_WR);
    ram_ce_d = ram_rd_d || ram_wr_d;
    done_d   = (state_d == S_D_WB) || (state_d == S_D_FIN) || (state_d == S_FAULT);
    err_d    = (state_d == S_FAULT);
    wb_en_d  = (state_d == S_D_WB);
    if_vld_d = (state_d == S_F_DONE);
    if (ram_ce_d) ram_addr_d = addr_d;
    if (ram_wr_d) ram_wdata_d = wdata_d;
    if (wb_en_d) wb_rd_d = rd_q;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
      fetch_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      if_vld_q    <= 1'b0;
      if_data_q   <= '0;
      ram_ce_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      fetch_q     <= fetch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      if_vld_q    <= if_vld_d;
      if_data_q   <= if_data_d;
      ram_ce_q    <= ram_ce_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign oRS2       = iIR[6:2];
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oERR       = err_q;
  assign oWB_EN     = wb_en_q;
  assign oWB_RD     = wb_rd_q;
  assign oWB_DATA   = wb_data_q;
  assign oIF_VLD    = if_vld_q;
  assign oIF_DATA   = if_data_q;
  assign oRAM_CE    = ram_ce_q;
  assign oRAM_RD    = ram_rd_q;
  assign oRAM_WR    = ram_wr_q;
  assign oRAM_ADDR  = ram_addr_q;
  assign oRAM_WDATA = ram_wdata_q;

endmodule

// File: tb/tb_rv32c_sp_mem_ctrl.sv
// Bench for rv32c_sp_mem_ctrl: four instances (RAM_LAT 1..4) share one stimulus
// stream and are checked against an arithmetic model of c.lwsp/c.swsp/fetch.
module tb_rv32c_sp_mem_ctrl;
  localparam int NI = 4;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic        iRST_N, iVALID;
  logic [15:0] iIR;
  logic [31:0] iSP, iRS2_DATA;
  logic [7:0]  iIF_ADDR;
  logic        ifReq [NI];

  logic [4:0]  rs2 [NI];
  logic        busy [NI], done [NI], err [NI], wbEn [NI], ifVld [NI];
  logic        ramCe [NI], ramRd [NI], ramWr [NI];
  logic [4:0]  wbRd [NI];
  logic [31:0] wbData [NI], ifData [NI], ramWdata [NI], ramData [NI];
  logic [7:0]  ramAddr [NI];

  logic [31:0] modelMem [256];
  int assertCount = 0;
  int failCount = 0;

  int doneCyc [NI], doneCount [NI], errCount [NI], wbCount [NI], busyCount [NI];
  int ceCount [NI], rdCount [NI], wrCount [NI], bothCount [NI], ifCyc [NI];
  logic [4:0]  wbRdSeen [NI];
  logic [31:0] wbDataSeen [NI], wrData [NI], ifDataSeen [NI];
  logic [7:0]  rdFirst [NI], rdLast [NI], wrAddr [NI];

  function automatic logic [31:0] initWord(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gInst
    logic [31:0] mem [256];
    logic [31:0] pipe [g+1];

    initial for (int i = 0; i < 256; i++) mem[i] = initWord(i);

    // RAM model: read data appears g+1 cycles after the issue cycle.
    always @(posedge iCLK) begin
      if (ramCe[g] && ramWr[g]) mem[ramAddr[g]] <= ramWdata[g];
      pipe[0] <= (ramCe[g] && ramRd[g]) ? mem[ramAddr[g]] : 32'h0BADF00D;
      for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
    end
    assign ramData[g] = pipe[g];

    rv32c_sp_mem_ctrl #(.RAM_LAT(g + 1)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iVALID(iVALID), .iIR(iIR), .iSP(iSP),
      .iRS2_DATA(iRS2_DATA), .oRS2(rs2[g]), .oBUSY(busy[g]), .oDONE(done[g]),
      .oERR(err[g]), .oWB_EN(wbEn[g]), .oWB_RD(wbRd[g]), .oWB_DATA(wbData[g]),
      .iIF_REQ(ifReq[g]), .iIF_ADDR(iIF_ADDR), .oIF_VLD(ifVld[g]),
      .oIF_DATA(ifData[g]), .oRAM_CE(ramCe[g]), .oRAM_RD(ramRd[g]),
      .oRAM_WR(ramWr[g]), .oRAM_ADDR(ramAddr[g]), .oRAM_WDATA(ramWdata[g]),
      .iRAM_DATA(ramData[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("lat%0d %s ctrl", g + 1, tag),
                  {24'd0, busy[g], done[g], err[g], wbEn[g], ifVld[g], ramCe[g], ramRd[g], ramWr[g]}, 32'd0);
      checkOutput($sformatf("lat%0d %s addr/rd", g + 1, tag), {19'd0, wbRd[g], ramAddr[g]}, 32'd0);
      checkOutput($sformatf("lat%0d %s data", g + 1, tag), wbData[g] | ifData[g] | ramWdata[g], 32'd0);
    end
  endtask

  // Watches every instance for a fixed window; cycle 1 is the cycle after the strobe edge.
  task automatic monitor(input int cycles);
    for (int g = 0; g < NI; g++) begin
      doneCyc[g] = 0; doneCount[g] = 0; errCount[g] = 0; wbCount[g] = 0; busyCount[g] = 0;
      ceCount[g] = 0; rdCount[g] = 0; wrCount[g] = 0; bothCount[g] = 0; ifCyc[g] = 0;
    end
    for (int c = 1; c <= cycles; c++) begin
      @(negedge iCLK);
      iVALID = 1'b0;
      for (int g = 0; g < NI; g++) begin
        if (done[g]) begin doneCount[g]++; if (doneCyc[g] == 0) doneCyc[g] = c; end
        if (err[g]) errCount[g]++;
        if (busy[g]) busyCount[g]++;
        if (wbEn[g]) begin wbCount[g]++; wbRdSeen[g] = wbRd[g]; wbDataSeen[g] = wbData[g]; end
        if (ramCe[g]) ceCount[g]++;
        if (ramRd[g] && ramWr[g]) bothCount[g]++;
        if (ramCe[g] && ramRd[g]) begin
          if (rdCount[g] == 0) rdFirst[g] = ramAddr[g];
          rdLast[g] = ramAddr[g];
          rdCount[g]++;
        end
        if (ramCe[g] && ramWr[g]) begin wrCount[g]++; wrAddr[g] = ramAddr[g]; wrData[g] = ramWdata[g]; end
        if (ifVld[g]) begin
          if (ifCyc[g] == 0) begin ifCyc[g] = c; ifDataSeen[g] = ifData[g]; end
          ifReq[g] = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ir, input logic [31:0] sp,
                               input logic [31:0] wd, input bit doFetch, input logic [7:0] fAddr);
    bit isLw, isSw, legal, fault;
    int off, rd, word, lat, expLat, expIf, expCe;
    logic [31:0] sum, expWb;
    isLw  = (ir % 4 == 2) && (ir / 8192 == 2);
    isSw  = (ir % 4 == 2) && (ir / 8192 == 6);
    legal = isLw || isSw;
    rd    = int'((ir / 128) % 32);
    if (isLw) off = int'(((ir / 4) % 4) * 64 + ((ir / 4096) % 2) * 32 + ((ir / 16) % 8) * 4);
    else      off = int'(((ir / 128) % 4) * 64 + ((ir / 512) % 16) * 4);
    sum   = sp + 32'(off);
    word  = int'((sum / 4) % 256);
    fault = legal && ((sum % 4 != 0) || (isLw && rd == 0));

    @(negedge iCLK);
    iVALID = 1'b1; iIR = ir; iSP = sp; iRS2_DATA = wd; iIF_ADDR = fAddr;
    for (int g = 0; g < NI; g++) ifReq[g] = doFetch;
    #1 checkOutput("rs2 index", 32'(rs2[0]), 32'((ir / 4) % 32));
    monitor(24);

    expWb = modelMem[word];
    if (legal && !fault && isSw) modelMem[word] = wd;
    expCe = ((legal && !fault) ? 1 : 0) + (doFetch ? 1 : 0);

    for (int g = 0; g < NI; g++) begin
      lat    = g + 1;
      expLat = !legal ? 0 : fault ? 1 : isSw ? 2 : lat + 2;
      expIf  = doFetch ? ((legal ? expLat + 1 : 0) + lat + 2) : 0;
      checkOutput($sformatf("lat%0d done cycle", lat), 32'(doneCyc[g]), 32'(expLat));
      checkOutput($sformatf("lat%0d done count", lat), 32'(doneCount[g]), legal ? 32'd1 : 32'd0);
      checkOutput($sformatf("lat%0d err count", lat), 32'(errCount[g]), fault ? 32'd1 : 32'd0);
      checkOutput($sformatf("lat%0d wb count", lat), 32'(wbCount[g]), (isLw && !fault) ? 32'd1 : 32'd0);
      checkOutput($sformatf("lat%0d ram ce count", lat), 32'(ceCount[g]), 32'(expCe));
      checkOutput($sformatf("lat%0d rd+wr overlap", lat), 32'(bothCount[g]), 32'd0);
      checkOutput($sformatf("lat%0d wr count", lat), 32'(wrCount[g]), (isSw && !fault) ? 32'd1 : 32'd0);
      if (!doFetch) checkOutput($sformatf("lat%0d busy cycles", lat), 32'(busyCount[g]), 32'(expLat));
      if (isLw && !fault && wbCount[g] == 1) begin
        checkOutput($sformatf("lat%0d wb rd", lat), 32'(wbRdSeen[g]), 32'(rd));
        checkOutput($sformatf("lat%0d wb data", lat), wbDataSeen[g], expWb);
        checkOutput($sformatf("lat%0d read addr", lat), 32'(rdFirst[g]), 32'(word));
      end
      if (isSw && !fault && wrCount[g] == 1) begin
        checkOutput($sformatf("lat%0d write addr", lat), 32'(wrAddr[g]), 32'(word));
        checkOutput($sformatf("lat%0d write data", lat), wrData[g], wd);
      end
      checkOutput($sformatf("lat%0d fetch cycle", lat), 32'(ifCyc[g]), 32'(expIf));
      if (doFetch && ifCyc[g] != 0) begin
        checkOutput($sformatf("lat%0d fetch data", lat), ifDataSeen[g], modelMem[fAddr]);
        checkOutput($sformatf("lat%0d fetch addr", lat), 32'(rdLast[g]), 32'(fAddr));
      end
      ifReq[g] = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] ir;
    logic [31:0] sp;
    int sel;
    for (int i = 0; i < 256; i++) modelMem[i] = initWord(i);
    iRST_N = 1'b1; iVALID = 1'b0; iIR = '0; iSP = '0; iRS2_DATA = '0; iIF_ADDR = '0;
    for (int g = 0; g < NI; g++) ifReq[g] = 1'b0;
    #2 iRST_N = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus(16'hC626, 32'h100, 32'hDEADBEEF, 1'b0, 8'h00);
    applyStimulus(16'h4432, 32'h100, 32'h0, 1'b0, 8'h00);
    applyStimulus(16'hC426, 32'h100, 32'h12345678, 1'b0, 8'h00);
    applyStimulus(16'h4432, 32'h102, 32'h0, 1'b0, 8'h00);
    applyStimulus(16'h4032, 32'h100, 32'h0, 1'b0, 8'h00);
    applyStimulus(16'h4432, 32'h100, 32'h0, 1'b1, 8'h05);
    applyStimulus(16'h4432, 32'h3FC, 32'h0, 1'b0, 8'h00);
    applyStimulus(16'h0000, 32'h0, 32'h0, 1'b1, 8'h42);
    applyStimulus(16'h4432, 32'h102, 32'h0, 1'b1, 8'h17);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 40; n++) begin
      ir  = 16'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel <= 2)      ir = {3'b010, ir[12:2], 2'b10};
      else if (sel <= 5) ir = {3'b110, ir[12:2], 2'b10};
      else if (sel == 6) ir = {ir[15:2], 2'b10};
      sp = $urandom;
      if ($urandom_range(0, 3) != 0) sp = sp & 32'hFFFFFFFC;
      applyStimulus(ir, sp, $urandom, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("[TB] reset during wait");
    @(negedge iCLK);
    iVALID = 1'b1; iIR = 16'h4432; iSP = 32'h100;
    @(negedge iCLK);
    iVALID = 1'b0;
    @(negedge iCLK);
    #1 iRST_N = 1'b0;
    #1 checkResetOutputs("async reset");
    @(negedge iCLK);
    iRST_N = 1'b1;
    monitor(10);
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("lat%0d post-reset done", g + 1), 32'(doneCount[g]), 32'd0);
      checkOutput($sformatf("lat%0d post-reset wb", g + 1), 32'(wbCount[g]), 32'd0);
      checkOutput($sformatf("lat%0d post-reset busy", g + 1), 32'(busyCount[g]), 32'd0);
    end
    applyStimulus(16'h4432, 32'h100, 32'h0, 1'b0, 8'h00);
    applyStimulus(16'hC426, 32'h104, 32'hCAFEF00D, 1'b1, 8'h43);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
